// File: rtl/msk_cst_stream_if.sv
// Handshake bundle for msk_cst_stream: public-word input, randomness input,
// masked-share output and fill level.
interface msk_cst_stream_if #(
  parameter int d     = 2,
  parameter int count = 8,
  parameter int depth = 4
);
  logic [count-1:0]         in_cst;
  logic                     in_valid;
  logic                     in_ready;
  logic [count*(d-1)-1:0]   rnd;
  logic                     rnd_valid;
  logic                     rnd_ready;
  logic [count*d-1:0]       out_sh;
  logic                     out_valid;
  logic                     out_ready;
  logic [$clog2(depth):0]   level;

  modport master (
    output in_cst, in_valid, rnd, rnd_valid, out_ready,
    input  in_ready, rnd_ready, out_sh, out_valid, level
  );

  modport slave (
    input  in_cst, in_valid, rnd, rnd_valid, out_ready,
    output in_ready, rnd_ready, out_sh, out_valid, level
  );
endinterface

// File: rtl/msk_cst_stream.sv
// FIFO storing a d-share Boolean masking of each pushed public word.
// Define MSK_CST_REFRESH_EN to mask with fresh randomness instead of zero shares.
module msk_cst_stream #(
  parameter int d     = 2,
  parameter int count = 8,
  parameter int depth = 4
) (
  input  logic               clk,
  input  logic               rst,
  msk_cst_stream_if.slave    bus
);
  localparam int PW = $clog2(depth);
  localparam int LW = PW + 1;
  localparam int SW = count * d;
  localparam logic [LW-1:0] LVL_FULL = LW'(depth);

  logic [SW-1:0] r_mem [depth];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [LW-1:0] r_level;

  logic [SW-1:0] w_enc;
  logic          w_rnd_ok;
  logic          w_in_ready;
  logic          w_push;
  logic          w_pop;
  logic          w_out_valid;

`ifdef MSK_CST_REFRESH_EN
  assign w_rnd_ok = bus.rnd_valid;

  // share0 absorbs the XOR of the masks so the sharing still recombines to in_cst
  always_comb begin
    w_enc = '0;
    for (int i = 0; i < count; i++) begin
      w_enc[i*d]           = bus.in_cst[i] ^ (^bus.rnd[i*(d-1) +: d-1]);
      w_enc[i*d+1 +: d-1]  = bus.rnd[i*(d-1) +: d-1];
    end
  end

  assign bus.rnd_ready = w_push;
`else
  logic w_unused;
  assign w_unused = ^{bus.rnd, bus.rnd_valid};
  assign w_rnd_ok = 1'b1;

  always_comb begin
    w_enc = '0;
    for (int i = 0; i < count; i++) begin
      w_enc[i*d] = bus.in_cst[i];
    end
  end

  assign bus.rnd_ready = 1'b0;
`endif

  // in_ready deliberately ignores out_ready: a full FIFO never accepts on a pop cycle
  assign w_in_ready  = !rst && (r_level < LVL_FULL) && w_rnd_ok;
  assign w_out_valid = (r_level != '0);
  assign w_push      = bus.in_valid && w_in_ready;
  assign w_pop       = w_out_valid && bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      for (int k = 0; k < depth; k++) begin
        r_mem[k] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= w_enc;
        r_wptr        <= r_wptr + PW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PW'(1);
      end
      if (w_push && !w_pop) begin
        r_level <= r_level + LW'(1);
      end else if (!w_push && w_pop) begin
        r_level <= r_level - LW'(1);
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_sh    = w_out_valid ? r_mem[r_rptr] : '0;
  assign bus.level     = r_level;
endmodule

// File: tb/tb_msk_cst_stream.sv
// Scoreboard bench for msk_cst_stream; builds with or without MSK_CST_REFRESH_EN.
module tb_msk_cst_stream;
  localparam int COUNT = 8;
  localparam int DEPTH = 4;
`ifdef MSK_CST_REFRESH_EN
  localparam int D       = 3;
  localparam bit REFRESH = 1'b1;
`else
  localparam int D       = 2;
  localparam bit REFRESH = 1'b0;
`endif
  localparam int SW = COUNT * D;
  localparam int RW = COUNT * (D - 1);

  logic clk = 1'b0;
  logic rst = 1'b1;

  msk_cst_stream_if #(.d(D), .count(COUNT), .depth(DEPTH)) bus ();

  msk_cst_stream #(.d(D), .count(COUNT), .depth(DEPTH)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int            n_checks = 0;
  int            n_pass   = 0;
  logic [SW-1:0] exp_q [$];
  int            mlevel   = 0;
  bit            m_ir;
  logic [SW-1:0] sh;
  bit            ok;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [SW-1:0] enc(input logic [COUNT-1:0] v, input logic [RW-1:0] r);
    logic [SW-1:0] s;
    logic          m;
    s = '0;
    for (int i = 0; i < COUNT; i++) begin
      m = v[i];
      if (REFRESH) begin
        for (int k = 0; k < D - 1; k++) begin
          s[i*D+1+k] = r[i*(D-1)+k];
          m          = m ^ r[i*(D-1)+k];
        end
      end
      s[i*D] = m;
    end
    return s;
  endfunction

  function automatic logic [RW-1:0] rnd_for(input logic [COUNT-1:0] v);
    logic [RW-1:0] x;
    for (int k = 0; k < RW; k++) x[k] = v[(k*3+1) % COUNT] ^ k[0];
    return x;
  endfunction

  // Monitor: independent level/handshake model plus in-order scoreboard pop
  always @(negedge clk) begin
    if (rst) begin
      mlevel = 0;
    end else begin
      m_ir = (mlevel < DEPTH) && (!REFRESH || bus.rnd_valid);
      check("in_ready", bus.in_ready, m_ir);
      check("level", bus.level, mlevel);
      check("out_valid", bus.out_valid, mlevel != 0);
      check("rnd_ready", bus.rnd_ready, REFRESH && bus.in_valid && m_ir);
      if (!bus.out_valid) begin
        check("out_sh_idle", bus.out_sh, 0);
      end else if (bus.out_ready) begin
        if (exp_q.size() == 0) check("sb_underflow", exp_q.size(), 1);
        else check("out_sh", bus.out_sh, exp_q.pop_front());
      end
      if (bus.in_valid && m_ir) mlevel++;
      if (bus.out_valid && bus.out_ready) mlevel--;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [COUNT-1:0] v);
    bit done;
    done = 1'b0;
    bus.in_cst   = v;
    bus.rnd      = rnd_for(v);
    bus.in_valid = 1'b1;
    for (int t = 0; t < 30 && !done; t++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        exp_q.push_back(enc(v, bus.rnd));
        done = 1'b1;
      end
      tick();
    end
    bus.in_valid = 1'b0;
    check("push_timeout", done, 1);
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    bus.out_ready = 1'b1;
    for (int t = 0; t < 40 && !done; t++) begin
      tick();
      if (!bus.out_valid) done = 1'b1;
    end
    bus.out_ready = 1'b0;
    check("drain_timeout", done, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_cst    = '0;
    bus.in_valid  = 1'b0;
    bus.rnd       = '0;
    bus.rnd_valid = REFRESH;
    bus.out_ready = 1'b0;

    // Reset state, including across a clock edge while held
    #2;
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_level", bus.level, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_sh", bus.out_sh, 0);
    check("rst_rnd_ready", bus.rnd_ready, 0);
    tick();
    check("rst_hold_level", bus.level, 0);
    #2 rst = 1'b0;
    #1 check("ir_after_rst", bus.in_ready, 1);
    tick();

`ifdef MSK_CST_REFRESH_EN
    // No randomness -> no push; with randomness -> single push, rnd_ready one cycle
    bus.rnd_valid = 1'b0;
    bus.in_cst    = 8'hFF;
    bus.rnd       = rnd_for(8'hFF);
    bus.in_valid  = 1'b1;
    @(negedge clk);
    check("norand_in_ready", bus.in_ready, 0);
    check("norand_rnd_ready", bus.rnd_ready, 0);
    tick();
    check("norand_level", bus.level, 0);
    bus.rnd_valid = 1'b1;
    @(negedge clk);
    check("rand_rnd_ready", bus.rnd_ready, 1);
    exp_q.push_back(enc(8'hFF, bus.rnd));
    tick();
    bus.in_valid = 1'b0;
    #1;
    check("rand_rnd_ready_drop", bus.rnd_ready, 0);
    check("rand_level", bus.level, 1);
    sh = bus.out_sh;
    for (int i = 0; i < COUNT; i++) begin
      check("share_xor", ^sh[i*D +: D], 1);
      check("share_rnd", sh[i*D+1 +: D-1], bus.rnd[i*(D-1) +: D-1]);
    end
    drain();
`endif

    // Single push of 0xA5, visible one cycle later
    push_one(8'hA5);
    check("a5_out_valid", bus.out_valid, 1);
    check("a5_level", bus.level, 1);
`ifdef MSK_CST_REFRESH_EN
    check("a5_out_sh", bus.out_sh, enc(8'hA5, rnd_for(8'hA5)));
`else
    check("a5_out_sh", bus.out_sh, 16'h4411);
    check("a5_odd_zero", bus.out_sh & 16'hAAAA, 0);
`endif
    drain();

    // Fill to full, fifth push refused
    for (int v = 1; v <= 4; v++) push_one(COUNT'(v));
    check("full_level4", bus.level, 4);
    bus.in_cst   = 8'h05;
    bus.rnd      = rnd_for(8'h05);
    bus.in_valid = 1'b1;
    @(negedge clk);
    check("full_in_ready", bus.in_ready, 0);
    tick();
    check("full_level_hold", bus.level, 4);

    // Full with pop: pop only, push accepted next cycle
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("full_pop_in_ready", bus.in_ready, 0);
    tick();
    check("pop_only_level", bus.level, 3);
    bus.out_ready = 1'b0;
    @(negedge clk);
    check("push_after_pop_ir", bus.in_ready, 1);
    if (bus.in_ready) exp_q.push_back(enc(8'h05, bus.rnd));
    tick();
    bus.in_valid = 1'b0;
    check("refill_level", bus.level, 4);
    drain();
    check("empty_level", bus.level, 0);

    // Steady stream: one transfer per cycle, pointers wrap several times
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.in_cst = COUNT'(8'h40 + i);
      bus.rnd    = rnd_for(bus.in_cst);
      @(negedge clk);
      if (i > 0) check("stream_level", bus.level, 1);
      check("stream_in_ready", bus.in_ready, 1);
      if (bus.in_ready) exp_q.push_back(enc(bus.in_cst, bus.rnd));
      tick();
    end
    bus.in_valid = 1'b0;
    drain();

    // Mid-operation reset with three entries
    push_one(8'h11);
    push_one(8'h22);
    push_one(8'h33);
    check("pre_rst_level", bus.level, 3);
    #2 rst = 1'b1;
    #1;
    check("arst_out_valid", bus.out_valid, 0);
    check("arst_level", bus.level, 0);
    check("arst_out_sh", bus.out_sh, 0);
    check("arst_in_ready", bus.in_ready, 0);
    exp_q.delete();
    tick();
    #2 rst = 1'b0;
    #1 check("ir_after_arst", bus.in_ready, 1);
    tick();
    push_one(8'h5A);
    check("post_rst_level", bus.level, 1);
    drain();

    tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
